cska_seq_adder: RTL and testbench

Multi-cycle wide adder that reuses one narrow carry-skip adder (`cska_top`) across several clock cycles. It accepts a WIDTH-bit operand pair over a valid/ready handshake and feeds the pair through the shared adder CHUNK bits per cycle, least-significant slice first, with the slice carry kept in a register. It returns the full sum and carry-out over a second valid/ready handshake. It sits between a request source and the combinational CSKA datapath, trading latency for adder area.

---
 rtl/cska_pkg.sv | 15 +
 rtl/cska_top.sv | 40 ++++
 rtl/cska_seq_adder.sv | 104 ++++++++++
 tb/tb_cska_seq_adder.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cska_pkg.sv
// Shared types and helpers for the carry-skip adder family.
package cska_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cska_seq_state_t;

    function automatic int unsigned cska_nslices(input int unsigned width,
                                                 input int unsigned chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/cska_top.sv
// Combinational N-bit carry-skip adder built from BLOCK_SIZE-bit ripple blocks.
module cska_top #(
    parameter int unsigned N          = 8,
    parameter int unsigned BLOCK_SIZE = 2
) (
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    input  logic         Cin,
    output logic [N-1:0] S,
    output logic         Cout
);

    logic c;
    logic blk_cin;
    logic rc;
    logic p;

    // Each block bypasses its ripple chain when every bit propagates.
    always_comb begin
        S       = '0;
        c       = Cin;
        blk_cin = Cin;
        rc      = Cin;
        p       = 1'b1;
        for (int unsigned blk = 0; blk < N / BLOCK_SIZE; blk++) begin
            blk_cin = c;
            rc      = c;
            p       = 1'b1;
            for (int unsigned j = 0; j < BLOCK_SIZE; j++) begin
                S[blk*BLOCK_SIZE+j] = A[blk*BLOCK_SIZE+j] ^ B[blk*BLOCK_SIZE+j] ^ rc;
                rc = (A[blk*BLOCK_SIZE+j] & B[blk*BLOCK_SIZE+j]) |
                     (rc & (A[blk*BLOCK_SIZE+j] ^ B[blk*BLOCK_SIZE+j]));
                p  = p & (A[blk*BLOCK_SIZE+j] ^ B[blk*BLOCK_SIZE+j]);
            end
            c = p ? blk_cin : rc;
        end
        Cout = c;
    end

endmodule

// File: rtl/cska_seq_adder.sv
// Multi-cycle WIDTH-bit adder that streams CHUNK-bit slices through one shared
// carry-skip adder, LSB slice first, with a registered inter-slice carry.
module cska_seq_adder
    import cska_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned CHUNK      = 8,
    parameter int unsigned BLOCK_SIZE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int unsigned NSLICES = cska_nslices(WIDTH, CHUNK);
    localparam int unsigned CNT_W   = (NSLICES > 1) ? $clog2(NSLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_SLICE = CNT_W'(NSLICES - 1);

    if (WIDTH % CHUNK != 0) begin : g_bad_width
        $error("cska_seq_adder: WIDTH must be a multiple of CHUNK");
    end
    if (CHUNK % BLOCK_SIZE != 0) begin : g_bad_chunk
        $error("cska_seq_adder: CHUNK must be a multiple of BLOCK_SIZE");
    end

    cska_seq_state_t  state_q;
    cska_seq_state_t  state_d;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] sum_sh;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic [CHUNK-1:0] slice_sum;
    logic             slice_cout;
    logic             accept;

    cska_top #(
        .N          (CHUNK),
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_add (
        .A    (a_sh[CHUNK-1:0]),
        .B    (b_sh[CHUNK-1:0]),
        .Cin  (carry_q),
        .S    (slice_sum),
        .Cout (slice_cout)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_sh;
    assign cout      = carry_q;
    assign accept    = in_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)           state_d = RUN;
            RUN:     if (cnt == LAST_SLICE)  state_d = DONE;
            DONE:    if (out_ready)          state_d = IDLE;
            default:                         state_d = IDLE;
        endcase
    end

    // Shift-based insert keeps the NSLICES==1 case legal (no zero-width slice).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            sum_sh  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state_q == RUN) begin
            a_sh    <= a_sh >> CHUNK;
            b_sh    <= b_sh >> CHUNK;
            sum_sh  <= (sum_sh >> CHUNK) | (WIDTH'(slice_sum) << (WIDTH - CHUNK));
            carry_q <= slice_cout;
            cnt     <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_cska_seq_adder.sv
// Scoreboard bench for cska_seq_adder: one instance with CHUNK=8, one with CHUNK=32.
module tb_cska_seq_adder;

    typedef struct packed {
        logic        c;
        logic [31:0] s;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        cin = 1'b0;
    logic        sel = 1'b0;
    logic        rand_ready = 1'b0;

    logic        iv0, rdy0, ov0, busy0, cout0;
    logic        iv1, rdy1, ov1, busy1, cout1;
    logic [31:0] sum0, sum1;

    res_t q0[$];
    res_t q1[$];
    res_t exp0, exp1;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [31:0] tv_a [7] = '{32'h12345678, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h80000000,
                              32'h0000FFFF, 32'hFFFFFFFF, 32'h00FF00FF};
    logic [31:0] tv_b [7] = '{32'h9ABCDEF0, 32'h55555555, 32'h55555555, 32'h80000000,
                              32'h00000001, 32'hFFFFFFFF, 32'h00010001};
    logic        tv_c [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] tv_s [7] = '{32'hACF13569, 32'h00000000, 32'hFFFFFFFF, 32'h00000000,
                              32'h00010000, 32'hFFFFFFFF, 32'h01000100};
    logic        tv_o [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    assign iv0 = in_valid && !sel;
    assign iv1 = in_valid && sel;

    always #5 clk = ~clk;

    cska_seq_adder #(.WIDTH(32), .CHUNK(8), .BLOCK_SIZE(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(rdy0), .a(a), .b(b), .cin(cin),
        .out_valid(ov0), .out_ready(out_ready), .sum(sum0), .cout(cout0), .busy(busy0)
    );

    cska_seq_adder #(.WIDTH(32), .CHUNK(32), .BLOCK_SIZE(4)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(rdy1), .a(a), .b(b), .cin(cin),
        .out_valid(ov1), .out_ready(out_ready), .sum(sum1), .cout(cout1), .busy(busy1)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic logic cur_rdy();  return sel ? rdy1 : rdy0;  endfunction
    function automatic logic cur_ov();   return sel ? ov1 : ov0;    endfunction
    function automatic logic cur_busy(); return sel ? busy1 : busy0; endfunction
    function automatic logic [31:0] cur_sum(); return sel ? sum1 : sum0; endfunction
    function automatic logic cur_cout(); return sel ? cout1 : cout0; endfunction

    // Monitors: compare every presented result against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && ov0 && out_ready) begin
            if (q0.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL result0: got unexpected 0x%0h cout %0b, expected no result", sum0, cout0);
            end else begin
                exp0 = q0.pop_front();
                chk("result0", {31'b0, cout0, sum0}, {31'b0, exp0.c, exp0.s});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && ov1 && out_ready) begin
            if (q1.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL result1: got unexpected 0x%0h cout %0b, expected no result", sum1, cout1);
            end else begin
                exp1 = q1.pop_front();
                chk("result1", {31'b0, cout1, sum1}, {31'b0, exp1.c, exp1.s});
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                        input logic [31:0] es, input logic ec, input bit push);
        bit ok;
        res_t e;
        ok = 1'b0;
        @(negedge clk);
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (cur_rdy()) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            chk("accept_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        if (push) begin
            e.s = es; e.c = ec;
            if (sel) q1.push_back(e); else q0.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cur_rdy()) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("idle_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_latency(input int n);
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("latency_ov_edge%0d", i), {63'b0, cur_ov()}, {63'b0, 1'(i == n)});
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 1000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge clk);
        end
    endtask

    task automatic run_vectors();
        for (int i = 0; i < 7; i++) begin
            send(tv_a[i], tv_b[i], tv_c[i], tv_s[i], tv_o[i], 1'b1);
            wait_idle();
        end
    endtask

    task automatic run_random(input int count);
        logic [31:0] ra, rb;
        logic        rc;
        logic [32:0] ref_v;
        rand_ready = 1'b1;
        for (int i = 0; i < count; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            ref_v = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            send(ra, rb, rc, ref_v[31:0], ref_v[32], 1'b1);
        end
        drain();
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        chk("rst_out_valid", {63'b0, ov0}, 64'd0);
        chk("rst_busy", {63'b0, busy0}, 64'd0);
        chk("rst_sum", {32'b0, sum0}, 64'd0);
        chk("rst_cout", {63'b0, cout0}, 64'd0);
        #10 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {63'b0, rdy0}, 64'd1);

        // Carry ripples through every slice; latency of four edges.
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1);
        check_latency(4);
        wait_idle();
        run_vectors();

        // Backpressure with garbage on the request side.
        out_ready = 1'b0;
        send(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'hACF13569, 1'b0, 1'b1);
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !ov0; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a = $urandom; b = $urandom; cin = ~cin;
            chk("bp_sum", {32'b0, sum0}, {32'b0, 32'hACF13569});
            chk("bp_cout", {63'b0, cout0}, 64'd0);
            chk("bp_out_valid", {63'b0, ov0}, 64'd1);
            chk("bp_in_ready", {63'b0, rdy0}, 64'd0);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", {63'b0, rdy0}, 64'd1);
        chk("bp_release_out_valid", {63'b0, ov0}, 64'd0);

        // Abort after two slices; result must never be presented.
        send(32'h12345678, 32'h9ABCDEF0, 1'b1, 32'h0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", {63'b0, ov0}, 64'd0);
        chk("abort_busy", {63'b0, busy0}, 64'd0);
        chk("abort_sum", {32'b0, sum0}, 64'd0);
        chk("abort_cout", {63'b0, cout0}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", {63'b0, rdy0}, 64'd1);
        send(32'h00000003, 32'h00000004, 1'b0, 32'h00000007, 1'b0, 1'b1);
        wait_idle();

        run_random(150);

        // Single-slice configuration.
        sel = 1'b1;
        @(negedge clk);
        send(32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b1);
        check_latency(1);
        wait_idle();
        run_vectors();
        run_random(100);

        drain();
        chk("q0_leftover", 64'(q0.size()), 64'd0);
        chk("q1_leftover", 64'(q1.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
